commit_stream_arb: RTL and testbench
====================================

# commit_stream_arb

Merges the per-issue-slot commit streams of the execute units (ALU, LSU, FPU, SFU) into the single commit stream consumed by the commit stage. It sits directly downstream of the SFU gather output and its sibling units. Packets are selected round-robin. Multi-packet instructions (`NUM_LANES < NUM_THREADS`, `sop`…`eop` sequences) are never interleaved. The result is registered through a 2-entry elastic buffer, and the block counts retired instructions.

## Interface
Parameters:
- `NUM_INPUTS`, 4, number of execute-unit commit streams; index 0 has the highest initial priority.
- `NUM_LANES`, `` `NUM_THREADS ``, lanes per commit packet; sets the packet width via the package.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset; state clears on a rising edge where `reset`=0.
- `in_valid`  in  `NUM_INPUTS`  per-input packet valid.
- `in_ready`  out  `NUM_INPUTS`  per-input accept.
- `in_data`  in  `NUM_INPUTS` x `COMMIT_DATAW`  `commit_pkt_t` per input: `wid`, `uuid`, `tmask`, `PC`, `wb`, `rd`, `data`, `pid`, `sop`, `eop`.
- `out_valid`  out  1  packet available.
- `out_ready`  in  1  downstream accept.
- `out_data`  out  `COMMIT_DATAW`  selected packet, unmodified.
- `out_sel`  out  `` `CLOG2(NUM_INPUTS) ``  source index of `out_data`.
- `instret`  out  64  count of retired instructions (`eop` packets delivered).

## Operation
- **Arbitration.** Candidates are the inputs with `in_valid`=1. The grant goes to the first candidate at or after `rr_ptr`, searching in increasing index order with wrap.
- **Lock.**
  - When a granted packet with `eop`=0 transfers, `lock_valid`←1 and `lock_idx`←grant.
  - While `lock_valid`=1, only `lock_idx` is eligible. Other inputs see `in_ready`=0 even if the buffer has space.
  - `lock_valid`←0 when the `eop`=1 packet from `lock_idx` transfers.
  - A packet with `sop`=1 and `eop`=1 never locks.
- **Pointer update.** `rr_ptr`←(grant+1) mod `NUM_INPUTS`, only on transfer of an `eop`=1 packet. It does not move during a locked sequence.
- **Input accept.** `in_ready[i]` = buffer not full AND i is the current grant. At most one input transfers per cycle.
- **Elastic buffer.** Holds 2 entries of `{data, sel}`, FIFO order.
  - Push on an input transfer; pop on `out_valid`&&`out_ready`.
  - Simultaneous push and pop keep the occupancy unchanged.
- **Retire counter.** `instret`←`instret`+1 on each output transfer with `eop`=1. It wraps from 2^64-1 to 0.
- **Malformed input.** An `sop`=1 arriving while locked on a different input is not accepted (that input has ready=0). No error flag is raised.

## Timing
- **Reset values:**
  - `out_valid`=0, `in_ready`=all 0 during the reset cycle, `out_sel`=0, `out_data`=0, `instret`=0.
  - `rr_ptr`=0, `lock_valid`=0, buffer empty.
- **First cycle after reset** with `in_valid[k]`=1: `in_ready[k]`=1.
- **Latency:** an input transfer in cycle N gives `out_valid`=1 in cycle N+1. There is no combinational path from `in_*` to `out_*`.
- **Throughput:** 1 packet/cycle while `out_ready`=1.
- **`in_ready` timing:** depends only on registered state and `in_valid`, never on `out_ready` (this cuts the backpressure path).
- **Backpressure:**
  - With `out_ready`=0 the buffer fills after 2 transfers. All `in_ready` then go 0 from the next cycle.
  - `out_data` stays stable while `out_valid`=1 and `out_ready`=0.
- **Full buffer:** a full buffer with a pop in the same cycle still refuses a push that cycle, because full is registered.
- **Reset mid-sequence:** reset taken mid-sequence drops the lock and buffered packets. Upstream units are reset in the same cycle.

## Structure
- `VX_gpu_pkg` gains:
  - `commit_pkt_t` (packed struct of the fields above).
  - `COMMIT_DATAW = $bits(commit_pkt_t)`.
  - `localparam COMMIT_EX_ALU=0, COMMIT_EX_LSU=1, COMMIT_EX_FPU=2, COMMIT_EX_SFU=3`.
- One sub-module, `commit_skid_buf`: the 2-entry elastic buffer, parameterised by `DATAW`, with a registered full/empty.
- Arbiter, lock and counter logic stay in the top module.

## Test plan
- **Reset check:** hold `reset`=0 for 3 cycles with all `in_valid`=1 → `out_valid`=0, `instret`=0, no `in_ready` asserted. After release, input 0 is granted first.
- **Fairness:** all 4 inputs continuously valid with single-packet instructions, `out_ready`=1 → `out_sel` sequence 0,1,2,3,0,…; `instret`=8 after 8 outputs.
- **Lock:** input 1 sends `sop`/—/`eop` (3 packets, `pid` 0..2) while input 0 is always valid.
  - Output order is 1,1,1 contiguous, then 0.
  - `instret` increments once for the sequence.
- **Backpressure:** `out_ready`=0 for 5 cycles with input 2 valid.
  - Exactly 2 packets are accepted; `out_data` stays stable.
  - After `out_ready`=1, packets drain in order with no loss or duplication.
- **Wrap:** `instret` forced to 2^64-1, then one `eop` transfer → `instret`=0.
- **Reset mid-lock:** reset after input 3's `sop` packet.
  - `lock_valid`=0 and the buffer is empty.
  - Next grant follows `rr_ptr`=0.

Source files
------------

// File: rtl/commit_stream_arb_pkg.sv
// Shared commit-path types: the commit packet layout and the execute-unit
// stream indices that feed commit_stream_arb.
package VX_gpu_pkg;

    localparam int NUM_THREADS = 4;
    localparam int NUM_LANES   = NUM_THREADS;
    localparam int XLEN        = 32;
    localparam int NW_BITS     = 4;
    localparam int UUID_BITS   = 32;
    localparam int NR_BITS     = 5;
    localparam int PID_BITS    = 2;

    // eop must remain the last field: the arbiter reads it as bit 0 of a packet.
    typedef struct packed {
        logic [NW_BITS-1:0]              wid;
        logic [UUID_BITS-1:0]            uuid;
        logic [NUM_LANES-1:0]            tmask;
        logic [XLEN-1:0]                 PC;
        logic                            wb;
        logic [NR_BITS-1:0]              rd;
        logic [NUM_LANES-1:0][XLEN-1:0]  data;
        logic [PID_BITS-1:0]             pid;
        logic                            sop;
        logic                            eop;
    } commit_pkt_t;

    localparam int COMMIT_DATAW = $bits(commit_pkt_t);

    localparam int COMMIT_EX_ALU = 0;
    localparam int COMMIT_EX_LSU = 1;
    localparam int COMMIT_EX_FPU = 2;
    localparam int COMMIT_EX_SFU = 3;

    function automatic int wrap_inc(int idx, int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/commit_skid_buf.sv
// Two-entry FIFO used as the registered output stage of the commit arbiter.
// Full and empty are flops so that upstream ready never sees downstream ready.
module commit_skid_buf #(
    parameter int DATAW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [DATAW-1:0] push_data,
    input  logic             pop,
    output logic             out_valid,
    output logic [DATAW-1:0] out_data,
    output logic             full
);

    logic [1:0][DATAW-1:0] mem;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic                  full_q;
    logic                  empty_q;
    logic                  push_ok;
    logic                  pop_ok;

    assign push_ok = push && !full_q;
    assign pop_ok  = pop && !empty_q;

    // With only two slots, the next full/empty follow from the current flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem     <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_ok, pop_ok})
                2'b10: begin
                    empty_q <= 1'b0;
                    full_q  <= !empty_q;
                end
                2'b01: begin
                    full_q  <= 1'b0;
                    empty_q <= !full_q;
                end
                default: ;
            endcase
        end
    end

    assign out_valid = !empty_q;
    assign out_data  = mem[rd_ptr];
    assign full      = full_q;

endmodule

// File: rtl/commit_stream_arb.sv
// Round-robin merge of the execute-unit commit streams into one registered
// commit stream; multi-packet instructions are kept contiguous via a lock.
module commit_stream_arb
    import VX_gpu_pkg::*;
#(
    parameter int  NUM_INPUTS = 4,
    localparam int SEL_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_INPUTS-1:0]                  in_valid,
    output logic [NUM_INPUTS-1:0]                  in_ready,
    input  logic [NUM_INPUTS-1:0][COMMIT_DATAW-1:0] in_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [COMMIT_DATAW-1:0]                out_data,
    output logic [SEL_W-1:0]                       out_sel,
    output logic [63:0]                            instret
);

    logic [SEL_W-1:0]      rr_ptr;
    logic [SEL_W-1:0]      lock_idx;
    logic                  lock_valid;
    logic [NUM_INPUTS-1:0] eligible;
    logic [SEL_W-1:0]      grant;
    logic                  grant_valid;
    logic                  grant_eop;
    logic                  push;
    logic                  buf_full;
    logic                  out_eop;
    logic [63:0]           instret_q;

    always_comb begin
        eligible = in_valid;
        if (lock_valid) begin
            eligible           = '0;
            eligible[lock_idx] = in_valid[lock_idx];
        end
    end

    // Walk downward so the lowest offset from rr_ptr wins the last assignment.
    always_comb begin
        int idx;
        idx         = 0;
        grant       = '0;
        grant_valid = 1'b0;
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_INPUTS) begin
                idx = idx - NUM_INPUTS;
            end
            if (eligible[idx]) begin
                grant       = SEL_W'(idx);
                grant_valid = 1'b1;
            end
        end
    end

    assign push      = reset && grant_valid && !buf_full;
    assign grant_eop = in_data[grant][0];

    always_comb begin
        in_ready = '0;
        if (push) begin
            in_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr     <= '0;
            lock_valid <= 1'b0;
            lock_idx   <= '0;
        end else if (push) begin
            if (grant_eop) begin
                lock_valid <= 1'b0;
                rr_ptr     <= SEL_W'(wrap_inc(int'(grant), NUM_INPUTS));
            end else begin
                lock_valid <= 1'b1;
                lock_idx   <= grant;
            end
        end
    end

    commit_skid_buf #(
        .DATAW (COMMIT_DATAW + SEL_W)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({in_data[grant], grant}),
        .pop       (out_ready),
        .out_valid (out_valid),
        .out_data  ({out_data, out_sel}),
        .full      (buf_full)
    );

    assign out_eop = out_data[0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            instret_q <= '0;
        end else if (out_valid && out_ready && out_eop) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign instret = instret_q;

endmodule

// File: tb/tb_commit_stream_arb.sv
// Directed and random checks of commit_stream_arb against a queue-based
// transaction model of arbitration, locking and the two-slot output stage.
module tb_commit_stream_arb;
    import VX_gpu_pkg::*;

    localparam int N = 4;

    logic                          clk = 1'b0;
    logic                          reset = 1'b0;
    logic [N-1:0]                  in_valid;
    logic [N-1:0]                  in_ready;
    logic [N-1:0][COMMIT_DATAW-1:0] in_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [COMMIT_DATAW-1:0]       out_data;
    logic [1:0]                    out_sel;
    logic [63:0]                   instret;

    always #5 clk = ~clk;

    commit_stream_arb #(.NUM_INPUTS(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .instret   (instret)
    );

    typedef struct {
        commit_pkt_t pkt;
        int          sel;
    } exp_t;

    exp_t        model_q[$];
    int          m_rr;
    bit          m_lock;
    int          m_lock_idx;
    logic [63:0] m_instret;
    bit          m_known;

    int          pend_len[N];
    int          pend_pos[N];
    commit_pkt_t cur[N];
    int          acc_idx;
    int          obs_sel[$];

    logic [N-1:0]            last_in_ready;
    logic                    last_out_valid;
    logic [COMMIT_DATAW-1:0] last_out_data;
    int                      n_vec;
    int                      n_err;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic commit_pkt_t rand_pkt(int pos, int len);
        commit_pkt_t p;
        p       = '0;
        p.wid   = NW_BITS'($urandom);
        p.uuid  = UUID_BITS'($urandom);
        p.tmask = NUM_LANES'($urandom);
        p.PC    = XLEN'($urandom);
        p.wb    = 1'($urandom);
        p.rd    = NR_BITS'($urandom);
        for (int l = 0; l < NUM_LANES; l++) p.data[l] = XLEN'($urandom);
        p.pid   = PID_BITS'(pos);
        p.sop   = (pos == 0);
        p.eop   = (pos == len - 1);
        return p;
    endfunction

    task automatic load(input int i, input int len);
        pend_len[i] = len;
        pend_pos[i] = 0;
        cur[i]      = rand_pkt(0, len);
    endtask

    task automatic clear_pend();
        for (int i = 0; i < N; i++) pend_len[i] = 0;
    endtask

    task automatic apply_stimulus();
        for (int i = 0; i < N; i++) begin
            in_valid[i] = (pend_len[i] != 0);
            in_data[i]  = cur[i];
        end
    endtask

    // Model: grant is the first valid input at or after the pointer (only the
    // locked input when a sequence is open); the output stage is a 2-deep queue.
    task automatic check_output();
        logic [N-1:0] exp_ready;
        int           grant;
        int           idx;
        exp_t         e;
        #1;
        exp_ready = '0;
        grant     = -1;
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_rr + k) % N;
                if (grant < 0 && in_valid[idx] && (!m_lock || idx == m_lock_idx)) grant = idx;
            end
            if (grant >= 0 && model_q.size() < 2) exp_ready[grant] = 1'b1;
        end
        if (!reset || m_known) chk("in_ready", 256'(in_ready), 256'(exp_ready));
        if (m_known) begin
            chk("out_valid", 256'(out_valid), 256'(model_q.size() > 0));
            if (model_q.size() > 0) begin
                chk("out_data", 256'(out_data), 256'(model_q[0].pkt));
                chk("out_sel", 256'(out_sel), 256'(model_q[0].sel));
            end
            chk("instret", 256'(instret), 256'(m_instret));
        end
        last_in_ready  = in_ready;
        last_out_valid = out_valid;
        last_out_data  = out_data;
        acc_idx        = -1;
        if (!reset) begin
            model_q.delete();
            m_rr      = 0;
            m_lock    = 0;
            m_instret = '0;
            m_known   = 1;
        end else if (m_known) begin
            if (out_valid && out_ready) obs_sel.push_back(int'(out_sel));
            if (out_ready && model_q.size() > 0) begin
                if (model_q[0].pkt.eop) m_instret++;
                void'(model_q.pop_front());
            end
            if (exp_ready != '0) begin
                e.pkt = commit_pkt_t'(in_data[grant]);
                e.sel = grant;
                model_q.push_back(e);
                acc_idx = grant;
                if (e.pkt.eop) begin
                    m_lock = 0;
                    m_rr   = (grant + 1) % N;
                end else begin
                    m_lock     = 1;
                    m_lock_idx = grant;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cycle();
        apply_stimulus();
        check_output();
        if (acc_idx >= 0) begin
            pend_pos[acc_idx]++;
            if (pend_pos[acc_idx] == pend_len[acc_idx]) pend_len[acc_idx] = 0;
            else cur[acc_idx] = rand_pkt(pend_pos[acc_idx], pend_len[acc_idx]);
        end
    endtask

    task automatic drain();
        clear_pend();
        out_ready = 1'b1;
        for (int t = 0; t < 10 && model_q.size() > 0; t++) cycle();
        chk("drain_empty", 256'(out_valid), 256'(0));
    endtask

    initial begin
        int          base;
        int          accepted;
        logic [COMMIT_DATAW-1:0] held;
        n_vec     = 0;
        n_err     = 0;
        m_known   = 0;
        m_rr      = 0;
        m_lock    = 0;
        m_instret = '0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b1;
        held      = '0;
        @(negedge clk);

        $display("[TB] reset with all inputs valid");
        for (int i = 0; i < N; i++) load(i, 1);
        repeat (3) cycle();
        chk("rst_in_ready", 256'(last_in_ready), 256'(0));
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_out_data", 256'(out_data), 256'(0));
        chk("rst_instret", 256'(instret), 256'(0));
        reset = 1'b1;
        cycle();
        chk("first_grant", 256'(last_in_ready), 256'(4'b0001));

        $display("[TB] fairness");
        for (int t = 0; t < 40 && obs_sel.size() < 8; t++) begin
            for (int i = 0; i < N; i++) if (pend_len[i] == 0) load(i, 1);
            cycle();
        end
        chk("fair_count", 256'(obs_sel.size()), 256'(8));
        chk("fair_instret", 256'(instret), 256'(8));
        for (int j = 0; j < 8 && j < obs_sel.size(); j++) chk("fair_sel", 256'(obs_sel[j]), 256'(j % 4));

        $display("[TB] locked sequence");
        drain();
        load(COMMIT_EX_ALU, 1);
        for (int t = 0; t < 5 && pend_len[COMMIT_EX_ALU] != 0; t++) cycle();
        drain();
        obs_sel.delete();
        base = int'(instret);
        load(COMMIT_EX_LSU, 3);
        load(COMMIT_EX_ALU, 1);
        for (int t = 0; t < 30 && obs_sel.size() < 4; t++) begin
            if (pend_len[COMMIT_EX_ALU] == 0) load(COMMIT_EX_ALU, 1);
            cycle();
        end
        chk("lock_count", 256'(obs_sel.size()), 256'(4));
        if (obs_sel.size() >= 4) begin
            chk("lock_sel0", 256'(obs_sel[0]), 256'(1));
            chk("lock_sel1", 256'(obs_sel[1]), 256'(1));
            chk("lock_sel2", 256'(obs_sel[2]), 256'(1));
            chk("lock_sel3", 256'(obs_sel[3]), 256'(0));
        end
        chk("lock_instret", 256'(instret), 256'(base + 2));

        $display("[TB] backpressure");
        drain();
        out_ready = 1'b0;
        accepted  = 0;
        for (int t = 0; t < 5; t++) begin
            if (pend_len[COMMIT_EX_FPU] == 0) load(COMMIT_EX_FPU, 1);
            cycle();
            if (acc_idx == COMMIT_EX_FPU) accepted++;
            if (t == 2) held = out_data;
        end
        chk("bp_accepted", 256'(accepted), 256'(2));
        chk("bp_stable", 256'(out_data), 256'(held));
        obs_sel.delete();
        drain();
        chk("bp_drained", 256'(obs_sel.size()), 256'(2));

        $display("[TB] retire counter wrap");
        force dut.instret_q = '1;
        #1;
        release dut.instret_q;
        m_instret = '1;
        obs_sel.delete();
        load(COMMIT_EX_ALU, 1);
        for (int t = 0; t < 10 && obs_sel.size() < 1; t++) cycle();
        chk("wrap_instret", 256'(instret), 256'(0));

        $display("[TB] reset inside a locked sequence");
        drain();
        load(COMMIT_EX_SFU, 2);
        for (int t = 0; t < 5 && pend_pos[COMMIT_EX_SFU] == 0; t++) cycle();
        load(COMMIT_EX_ALU, 1);
        reset = 1'b0;
        cycle();
        clear_pend();
        reset = 1'b1;
        load(COMMIT_EX_ALU, 1);
        load(COMMIT_EX_SFU, 1);
        cycle();
        chk("rml_out_valid", 256'(last_out_valid), 256'(0));
        chk("rml_grant", 256'(last_in_ready), 256'(4'b0001));

        $display("[TB] random traffic");
        drain();
        for (int t = 0; t < 800; t++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++)
                if (pend_len[i] == 0 && $urandom_range(0, 3) == 0) load(i, $urandom_range(1, 3));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
